// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg
// Shared definitions for the memory request controller.
// The FSM state encoding is fixed so that debug tools and neighbouring
// blocks can decode the state register directly:
//   IDLE  = 2'd0  waiting for a core request
//   WRITE = 2'd1  driving a one-cycle store strobe
//   READ  = 2'd2  holding rden while the read latency elapses
//   RESP  = 2'd3  presenting load data until the consumer takes it
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl
// Request controller placed directly upstream of memory_unit. It accepts one
// load/store at a time over a valid/ready handshake and drives the memory
// strobes, address and write data from registered state. Load data is sampled
// from mem_q after RD_LAT cycles of rden and returned over a valid/ready
// response channel. Stores are posted and produce no response.
//
// Parameters:
//   MEMSIZE  - address width (matches memory_unit)
//   WORDSIZE - data width (matches memory_unit)
//   RD_LAT   - cycles rden is held before mem_q is sampled (>= 1)
// Ports:
//   clk, rst                           - clock, async active-high reset
//   req_valid/req_ready                - request handshake
//   req_we, req_addr, req_wdata        - request kind, address, store data
//   resp_valid/resp_ready, resp_rdata  - load response channel
//   mem_wren, mem_rden, mem_addr, mem_d - to memory_unit
//   mem_q                              - from memory_unit
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int MEMSIZE  = 16,
  parameter int WORDSIZE = 4,
  parameter int RD_LAT   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [MEMSIZE-1:0]  req_addr,
  input  logic [WORDSIZE-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [WORDSIZE-1:0] resp_rdata,
  output logic                mem_wren,
  output logic                mem_rden,
  output logic [MEMSIZE-1:0]  mem_addr,
  output logic [WORDSIZE-1:0] mem_d,
  input  logic [WORDSIZE-1:0] mem_q
);

  // Counter only has to reach RD_LAT-1, so this width can never wrap.
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(RD_LAT - 1);

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic          accept_s;
  logic          rd_done_s;

  assign accept_s  = (state_r == IDLE) && req_valid;
  assign rd_done_s = (state_r == READ) && (cnt_r == LAST);

  // State register; reset returns to IDLE so all decoded outputs settle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_s = req_we ? WRITE : READ;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: state_s = IDLE;
      READ: begin
        if (cnt_r == LAST) begin
          state_s = RESP;
        end else begin
          state_s = READ;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode purely from the state register, so the strobes are
  // mutually exclusive and follow reset asynchronously.
  always_comb begin
    req_ready  = 1'b0;
    mem_wren   = 1'b0;
    mem_rden   = 1'b0;
    resp_valid = 1'b0;
    case (state_r)
      IDLE:    req_ready  = 1'b1;
      WRITE:   mem_wren   = 1'b1;
      READ:    mem_rden   = 1'b1;
      RESP:    resp_valid = 1'b1;
      default: req_ready  = 1'b0;
    endcase
  end

  // Datapath: request capture, read-latency counter and load-data capture.
  // mem_d is captured on loads too; memory ignores it when wren is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_d      <= '0;
      resp_rdata <= '0;
      cnt_r      <= '0;
    end else begin
      if (accept_s) begin
        mem_addr <= req_addr;
        mem_d    <= req_wdata;
        cnt_r    <= '0;
      end else if ((state_r == READ) && !rd_done_s) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      if (rd_done_s) begin
        resp_rdata <= mem_q;
      end else begin
        resp_rdata <= resp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Testbench for mem_req_ctrl: two instances (RD_LAT=1 and RD_LAT=3), each
// with a behavioural memory_unit model, checked against a reference memory
// updated at request acceptance.
module tb_mem_req_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance with RD_LAT = 1
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready;
  logic [15:0] req_addr, mem_addr;
  logic [3:0]  req_wdata, resp_rdata, mem_d, mem_q;
  logic        mem_wren, mem_rden;

  // Instance with RD_LAT = 3
  logic        req_valid3, req_ready3, req_we3, resp_valid3, resp_ready3;
  logic [15:0] req_addr3, mem_addr3;
  logic [3:0]  req_wdata3, resp_rdata3, mem_d3, mem_q3;
  logic        mem_wren3, mem_rden3;

  mem_req_ctrl #(.MEMSIZE(16), .WORDSIZE(4), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_addr(mem_addr),
    .mem_d(mem_d), .mem_q(mem_q)
  );

  mem_req_ctrl #(.MEMSIZE(16), .WORDSIZE(4), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid3), .req_ready(req_ready3), .req_we(req_we3),
    .req_addr(req_addr3), .req_wdata(req_wdata3),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_rdata(resp_rdata3),
    .mem_wren(mem_wren3), .mem_rden(mem_rden3), .mem_addr(mem_addr3),
    .mem_d(mem_d3), .mem_q(mem_q3)
  );

  // Behavioural memory_unit models: synchronous write, combinational read.
  logic [3:0] mem1 [0:65535];
  logic [3:0] mem3 [0:65535];
  always @(posedge clk) if (mem_wren) mem1[mem_addr] <= mem_d;
  always @(posedge clk) if (mem_wren3) mem3[mem_addr3] <= mem_d3;
  assign mem_q  = mem_rden  ? mem1[mem_addr]  : 4'h0;
  assign mem_q3 = mem_rden3 ? mem3[mem_addr3] : 4'h0;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int last_acc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: what the memory should contain after each accepted store.
  logic [3:0] ref_mem [int];

  function automatic logic [3:0] ref_get(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    else return 4'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_store(input logic [15:0] a, input logic [3:0] d);
    chk("st_ready_pre", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    tick;
    last_acc = cyc;
    req_valid = 1'b0;
    chk("st_wren", {31'd0, mem_wren}, 32'd1);
    chk("st_rden", {31'd0, mem_rden}, 32'd0);
    chk("st_addr", {16'd0, mem_addr}, {16'd0, a});
    chk("st_d", {28'd0, mem_d}, {28'd0, d});
    chk("st_busy", {31'd0, req_ready}, 32'd0);
    tick;
    chk("st_wren_off", {31'd0, mem_wren}, 32'd0);
    chk("st_ready_back", {31'd0, req_ready}, 32'd1);
    ref_mem[int'(a)] = d;
  endtask

  // Load with optional response back-pressure (hold cycles) and an optional
  // competing store held on the request port during back-pressure.
  task automatic do_load(input logic [15:0] a, input int hold, input bit conc);
    logic [3:0] exp;
    int lat;
    exp = ref_get(int'(a));
    lat = 0;
    chk("ld_ready_pre", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 4'($urandom);
    tick;
    req_valid = 1'b0;
    chk("ld_rden", {31'd0, mem_rden}, 32'd1);
    chk("ld_wren", {31'd0, mem_wren}, 32'd0);
    chk("ld_addr", {16'd0, mem_addr}, {16'd0, a});
    chk("ld_busy", {31'd0, req_ready}, 32'd0);
    while (!resp_valid && lat < 20) begin
      tick;
      lat++;
    end
    chk("ld_latency", lat, 32'd1);
    chk("ld_rden_off", {31'd0, mem_rden}, 32'd0);
    chk("ld_data", {28'd0, resp_rdata}, {28'd0, exp});
    resp_ready = (hold == 0);
    if (conc) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0042; req_wdata = 4'h9;
    end
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_data", {28'd0, resp_rdata}, {28'd0, exp});
      chk("hold_busy", {31'd0, req_ready}, 32'd0);
      chk("hold_no_wren", {31'd0, mem_wren}, 32'd0);
    end
    resp_ready = 1'b1;
    tick;
    chk("resp_done", {31'd0, resp_valid}, 32'd0);
    chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
    if (conc) begin
      chk("conc_not_yet", {31'd0, mem_wren}, 32'd0);
      tick;
      req_valid = 1'b0;
      chk("conc_accept", {31'd0, mem_wren}, 32'd1);
      chk("conc_addr", {16'd0, mem_addr}, 32'h0042);
      tick;
      ref_mem[32'h0042] = 4'h9;
    end
  endtask

  initial begin
    int lat3;
    int nrden3;
    int prev;
    logic [15:0] ra;

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_wdata = 4'h0; resp_ready = 1'b0;
    req_valid3 = 1'b0; req_we3 = 1'b0; req_addr3 = 16'h0; req_wdata3 = 4'h0; resp_ready3 = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      mem1[i] = 4'h0;
      mem3[i] = 4'h0;
    end
    tick;
    tick;
    rst = 1'b0;
    tick;

    // Reset state
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_wren", {31'd0, mem_wren}, 32'd0);
    chk("rst_rden", {31'd0, mem_rden}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);

    // Store A to 3, read it back
    do_store(16'd3, 4'hA);
    do_load(16'd3, 0, 1'b0);
    chk("a_at_3", {28'd0, resp_rdata}, 32'hA);

    // Store i -> 15-i, back to back, then read all 16
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      do_store(16'(15 - i), 4'(i));
      if (i > 0) chk("store_thruput", last_acc - prev, 32'd2);
      prev = last_acc;
    end
    for (int a = 0; a < 16; a++) begin
      do_load(16'(a), 0, 1'b0);
      chk("sweep_data", {28'd0, resp_rdata}, 32'(15 - a));
    end

    // Back-pressure 5 cycles with a competing store
    do_load(16'd3, 5, 1'b1);
    do_load(16'h0042, 0, 1'b0);

    // RD_LAT = 3 instance
    chk("l3_ready", {31'd0, req_ready3}, 32'd1);
    req_valid3 = 1'b1; req_we3 = 1'b1; req_addr3 = 16'd7; req_wdata3 = 4'h5;
    tick;
    req_valid3 = 1'b0;
    chk("l3_wren", {31'd0, mem_wren3}, 32'd1);
    tick;
    chk("l3_wren_off", {31'd0, mem_wren3}, 32'd0);
    req_valid3 = 1'b1; req_we3 = 1'b0; req_addr3 = 16'd7;
    tick;
    req_valid3 = 1'b0;
    lat3 = 0;
    nrden3 = 0;
    while (!resp_valid3 && lat3 < 20) begin
      if (mem_rden3) nrden3++;
      tick;
      lat3++;
    end
    chk("l3_latency", lat3, 32'd3);
    chk("l3_rden_cycles", nrden3, 32'd3);
    chk("l3_rden_off", {31'd0, mem_rden3}, 32'd0);
    chk("l3_data", {28'd0, resp_rdata3}, 32'h5);
    resp_ready3 = 1'b1;
    tick;
    chk("l3_resp_done", {31'd0, resp_valid3}, 32'd0);

    // Reset mid-READ
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd3;
    tick;
    req_valid = 1'b0;
    chk("mr_rden", {31'd0, mem_rden}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mr_rden_async", {31'd0, mem_rden}, 32'd0);
    chk("mr_ready_async", {31'd0, req_ready}, 32'd1);
    chk("mr_resp_valid", {31'd0, resp_valid}, 32'd0);
    tick;
    rst = 1'b0;
    chk("mr_addr_zero", {16'd0, mem_addr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("mr_no_resp", {31'd0, resp_valid}, 32'd0);
    end

    // Reset mid-WRITE (store to an address that is never read back)
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h00F0; req_wdata = 4'h6;
    tick;
    req_valid = 1'b0;
    chk("mw_wren", {31'd0, mem_wren}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mw_wren_async", {31'd0, mem_wren}, 32'd0);
    chk("mw_ready_async", {31'd0, req_ready}, 32'd1);
    tick;
    rst = 1'b0;
    tick;
    do_load(16'd3, 0, 1'b0);

    // Randomized traffic against the reference memory
    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) do_store(ra, 4'($urandom));
      else do_load(ra, $urandom_range(0, 2), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
# mem_req_ctrl

Request controller sitting directly upstream of `memory_unit`. It accepts single load/store requests from the core over a valid/ready handshake and drives `memory_unit`'s `wren`/`rden`/`addr`/`d` from registered state. It captures `q` after a configurable read latency and returns load data over a valid/ready response channel. Stores are posted and produce no response.

## Interface
- `MEMSIZE`, 16: address width in bits; matches `memory_unit` `MEMSIZE`.
- `WORDSIZE`, 4: data word width; matches `memory_unit` `WORDSIZE`.
- `RD_LAT`, 1: cycles `mem_rden` is held before `mem_q` is sampled. Must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in MEMSIZE: request address.
- `req_wdata` in WORDSIZE: store data.
- `resp_valid` out 1: load data valid.
- `resp_ready` in 1: consumer accepts the response.
- `resp_rdata` out WORDSIZE: load data.
- `mem_wren` out 1: to `memory_unit.wren`.
- `mem_rden` out 1: to `memory_unit.rden`.
- `mem_addr` out MEMSIZE: to `memory_unit.addr`.
- `mem_d` out WORDSIZE: to `memory_unit.d`.
- `mem_q` in WORDSIZE: from `memory_unit.q`.

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid & req_ready`, latch `req_addr`→`mem_addr` and `req_wdata`→`mem_d`.
  - Go to WRITE if `req_we`, else to READ with the latency counter set to 0.
- WRITE:
  - `mem_wren`=1 for exactly one cycle, then return to IDLE.
- READ:
  - `mem_rden`=1 while in this state; the counter increments each cycle.
  - When counter == RD_LAT-1, register `mem_q` into `resp_rdata` and go to RESP.
- RESP:
  - `resp_valid`=1.
  - `resp_rdata` stays stable until `resp_valid & resp_ready`, then return to IDLE.
- `req_ready`=0 in every state except IDLE. Requests presented outside IDLE are not consumed.
- `mem_wren`, `mem_rden`, `resp_valid` and `req_ready` are decoded only from the state register; they are glitch-free and never both `mem_wren` and `mem_rden` high.
- `mem_addr`/`mem_d` hold their last latched value in IDLE and RESP. `mem_d` is latched on loads as well and is don't-care to memory.
- Counter width is $clog2(RD_LAT+1); it never wraps.
- Reset, including mid-operation:
  - State→IDLE.
  - `mem_addr`, `mem_d`, `resp_rdata` and the counter →0.
  - `mem_wren`, `mem_rden`, `resp_valid` →0 immediately (asynchronously).
  - `req_ready` →1 immediately.
  - An in-flight store may be lost; an in-flight load produces no response.

## Timing
- Request accepted at edge N:
  - Store: `mem_wren` high during cycle N..N+1, `req_ready` high again from edge N+1 (back-to-back store throughput = 1 per 2 cycles).
  - Load: `mem_rden` high from edge N to edge N+RD_LAT; `mem_q` sampled at edge N+RD_LAT; `resp_valid` high from edge N+RD_LAT.
- Response consumed at edge M: `resp_valid` and `req_ready`… `resp_valid` falls and `req_ready` rises after edge M; the next request can be accepted at edge M+1.
- `mem_q` must be stable before the sampling edge; `memory_unit` is combinational in read, so RD_LAT=1 suffices.

## Structure
- Shared package `mem_ctrl_pkg`: state encoding constants (IDLE=2'd0, WRITE=2'd1, READ=2'd2, RESP=2'd3).
- No sub-module; the latency counter is inline.
- Top-level integration instantiates `mem_req_ctrl` next to `memory_unit` with identical MEMSIZE/WORDSIZE.

## Test plan
- Reset then idle → `req_ready`=1; `mem_wren`=`mem_rden`=`resp_valid`=0; `mem_addr`=0.
- Store addr 3, data 4'hA, then load addr 3 (RD_LAT=1, `resp_ready`=1) → one-cycle `mem_wren` with addr=3/d=A; `resp_valid` one cycle after rden, `resp_rdata`=4'hA.
- Store i→addr 15-i for i=0..15, then load all 16 addresses → `resp_rdata` = 15-addr each; verify `req_ready` timing and store throughput of 1 per 2 cycles.
- Load with `resp_ready`=0 for 5 cycles → `resp_valid` and `resp_rdata` held stable; `req_ready`=0; a concurrent `req_valid` is not accepted until the cycle after the handshake.
- RD_LAT=3, load addr 7 → `mem_rden` high exactly 3 cycles; `resp_valid` at acceptance+3; data correct.
- Assert `rst` mid-READ and mid-WRITE → outputs drop asynchronously; no `resp_valid`; a subsequent load returns correct data.
